uart_mem_bridge: RTL and testbench

Byte-serial command bridge between the UART receiver/transmitter pair and the HyperRAM controller request interface (`hyper_xface`). It supersedes the ad-hoc command decoder in the board top level. Address width, data width and burst length are parametrised. It issues multi-word burst reads and writes, buffers read bursts in a FIFO, and sends status-framed responses with an exact byte count. Malformed and stalled frames are detected and recovered.

---
 rtl/uart_mem_pkg.sv | 16 +
 rtl/bridge_fifo.sv | 49 ++++
 rtl/uart_mem_bridge.sv | 194 +++++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_pkg.sv
// Shared command/status codes and FSM states for the UART-to-HyperRAM bridge.
package uart_mem_pkg;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_PING   = 8'h03;

    localparam logic [7:0] ST_OK      = 8'hA5;
    localparam logic [7:0] ST_BAD_CMD = 8'hE1;
    localparam logic [7:0] ST_TIMEOUT = 8'hE2;
    localparam logic [7:0] ST_BAD_LEN = 8'hE3;

    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_ADDR, S_WDATA, S_WREQ,
        S_WWAIT, S_RREQ, S_RSEND, S_RESP, S_DRAIN
    } state_e;
endpackage

// File: rtl/bridge_fifo.sv
// Read-burst buffer: synchronous FIFO with first-word-fall-through output.
module bridge_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= inc(rd_ptr_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/uart_mem_bridge.sv
// Byte-serial command parser driving burst reads/writes on the HyperRAM request
// interface and returning status-framed responses over the UART transmitter.
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter int          DATA_BYTES     = 4,
    parameter int          ADDR_BYTES     = 4,
    parameter int          MAX_BURST      = 16,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [31:0] PING_ID        = 32'h0000_0103
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    tx_ready,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    output logic                    mem_rd_req,
    output logic                    mem_wr_req,
    output logic [8*ADDR_BYTES-1:0] mem_addr,
    output logic [8*DATA_BYTES-1:0] mem_wr_d,
    output logic [5:0]              mem_rd_num,
    input  logic [8*DATA_BYTES-1:0] mem_rd_d,
    input  logic                    mem_rd_rdy,
    input  logic                    mem_busy,
    output logic                    rx_overrun
);
    localparam int DW = 8 * DATA_BYTES;
    localparam int AW = 8 * ADDR_BYTES;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d, len_q, len_d, idx_q, idx_d, bcnt_q, bcnt_d;
    logic [7:0]    rbyte_q, rbyte_d, rwords_q, rwords_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rword_q, rword_d;
    logic [39:0]   resp_q, resp_d;
    logic [2:0]    rcnt_q, rcnt_d;
    logic          hdr_q, hdr_d, bseen_q, bseen_d, ovr_q, ovr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          out_q, low_q, tx_start_q;
    logic [7:0]    tx_data_q, tx_byte;
    logic          tx_go, tx_free, tmo_hit, parsing, counting;
    logic          push, pop, fifo_full, fifo_empty;
    logic [DW-1:0] fifo_dout;

    assign tx_free  = tx_ready && !out_q;
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES));
    assign parsing  = (state_q == S_IDLE) || (state_q == S_LEN) ||
                      (state_q == S_ADDR) || (state_q == S_WDATA);
    assign counting = (state_q == S_LEN) || (state_q == S_ADDR) ||
                      (state_q == S_WDATA) || (state_q == S_DRAIN);
    assign push     = mem_rd_rdy && !fifo_full &&
                      ((state_q == S_RREQ) || (state_q == S_RSEND));

    bridge_fifo #(.W(DW), .DEPTH(MAX_BURST)) u_fifo (
        .clk(clk), .reset(reset), .push_i(push), .din_i(mem_rd_d), .pop_i(pop),
        .dout_o(fifo_dout), .full_o(fifo_full), .empty_o(fifo_empty)
    );

    always_comb begin
        state_d  = state_q;   cmd_d   = cmd_q;   len_d    = len_q;    idx_d  = idx_q;
        bcnt_d   = bcnt_q;    addr_d  = addr_q;  wdata_d  = wdata_q;  resp_d = resp_q;
        rcnt_d   = rcnt_q;    hdr_d   = hdr_q;   rbyte_d  = rbyte_q;  rword_d = rword_q;
        rwords_d = rwords_q;  bseen_d = bseen_q;
        ovr_d    = ovr_q | (rx_valid && !parsing);
        tx_go    = 1'b0;
        tx_byte  = '0;
        pop      = 1'b0;
        if (!counting || rx_valid) tmo_d = '0;
        else if (!tmo_hit)         tmo_d = tmo_q + 1'b1;
        else                       tmo_d = tmo_q;

        case (state_q)
            S_IDLE: if (rx_valid) begin
                cmd_d  = rx_data;
                bcnt_d = '0;
                if (rx_data == CMD_PING) begin
                    resp_d = {ST_OK, PING_ID}; rcnt_d = 3'd5; state_d = S_RESP;
                end else if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                    state_d = S_LEN;
                end else begin
                    resp_d = {ST_BAD_CMD, 32'h0}; rcnt_d = 3'd1; state_d = S_DRAIN;
                end
            end
            S_LEN: if (rx_valid) begin
                if (rx_data == 8'h00 || rx_data > 8'(MAX_BURST)) begin
                    resp_d = {ST_BAD_LEN, 32'h0}; rcnt_d = 3'd1; state_d = S_DRAIN;
                end else begin
                    len_d = rx_data; state_d = S_ADDR;
                end
            end else if (tmo_hit) begin
                resp_d = {ST_TIMEOUT, 32'h0}; rcnt_d = 3'd1; state_d = S_RESP;
            end
            S_ADDR: if (rx_valid) begin
                addr_d = {addr_q[AW-9:0], rx_data};
                bcnt_d = bcnt_q + 8'd1;
                if (bcnt_q == 8'(ADDR_BYTES - 1)) begin
                    bcnt_d = '0; idx_d = '0; hdr_d = 1'b0; rbyte_d = '0; rwords_d = '0;
                    state_d = (cmd_q == CMD_WRITE) ? S_WDATA : S_RREQ;
                end
            end else if (tmo_hit) begin
                resp_d = {ST_TIMEOUT, 32'h0}; rcnt_d = 3'd1; state_d = S_RESP;
            end
            S_WDATA: if (rx_valid) begin
                wdata_d = {wdata_q[DW-9:0], rx_data};
                bcnt_d  = bcnt_q + 8'd1;
                if (bcnt_q == 8'(DATA_BYTES - 1)) state_d = S_WREQ;
            end else if (tmo_hit) begin
                resp_d = {ST_TIMEOUT, 32'h0}; rcnt_d = 3'd1; state_d = S_RESP;
            end
            S_WREQ: if (!mem_busy) begin
                bseen_d = 1'b0; state_d = S_WWAIT;
            end
            // A write completes only after the controller has visibly taken it.
            S_WWAIT: if (mem_busy) begin
                bseen_d = 1'b1;
            end else if (bseen_q) begin
                if (idx_q == len_q - 8'd1) begin
                    resp_d = {ST_OK, 32'h0}; rcnt_d = 3'd1; state_d = S_RESP;
                end else begin
                    idx_d = idx_q + 8'd1; bcnt_d = '0; state_d = S_WDATA;
                end
            end
            S_RREQ: if (!mem_busy) state_d = S_RSEND;
            S_RSEND: begin
                if (hdr_q && rbyte_q == '0 && rwords_q == len_q) begin
                    state_d = S_IDLE;
                end else if (tx_free) begin
                    if (!hdr_q) begin
                        tx_go = 1'b1; tx_byte = ST_OK; hdr_d = 1'b1;
                    end else if (rbyte_q != '0) begin
                        tx_go = 1'b1; tx_byte = rword_q[DW-1 -: 8];
                        rword_d = rword_q << 8; rbyte_d = rbyte_q - 8'd1;
                    end else if (!fifo_empty) begin
                        pop = 1'b1; tx_go = 1'b1; tx_byte = fifo_dout[DW-1 -: 8];
                        rword_d = fifo_dout << 8; rbyte_d = 8'(DATA_BYTES - 1);
                        rwords_d = rwords_q + 8'd1;
                    end
                end
            end
            S_RESP, S_DRAIN: begin
                if (rcnt_q != '0) begin
                    if (tx_free) begin
                        tx_go = 1'b1; tx_byte = resp_q[39:32];
                        resp_d = {resp_q[31:0], 8'h00}; rcnt_d = rcnt_q - 3'd1;
                    end
                end else if (state_q == S_RESP || (tmo_hit && !rx_valid)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;  cmd_q <= '0;    len_q <= 8'd1;  idx_q <= '0;
            bcnt_q  <= '0;      addr_q <= '0;   wdata_q <= '0;  resp_q <= '0;
            rcnt_q  <= '0;      hdr_q <= 1'b0;  rbyte_q <= '0;  rword_q <= '0;
            rwords_q <= '0;     bseen_q <= 1'b0; ovr_q <= 1'b0; tmo_q <= '0;
        end else begin
            state_q <= state_d;  cmd_q <= cmd_d;    len_q <= len_d;      idx_q <= idx_d;
            bcnt_q  <= bcnt_d;   addr_q <= addr_d;  wdata_q <= wdata_d;  resp_q <= resp_d;
            rcnt_q  <= rcnt_d;   hdr_q <= hdr_d;    rbyte_q <= rbyte_d;  rword_q <= rword_d;
            rwords_q <= rwords_d; bseen_q <= bseen_d; ovr_q <= ovr_d;    tmo_q <= tmo_d;
        end
    end

    // A byte stays outstanding until ready is seen low and then high again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= 1'b0; low_q <= 1'b0; tx_start_q <= 1'b0; tx_data_q <= '0;
        end else begin
            tx_start_q <= tx_go;
            if (tx_go) begin
                tx_data_q <= tx_byte; out_q <= 1'b1; low_q <= 1'b0;
            end else if (out_q) begin
                if (!tx_ready)  low_q <= 1'b1;
                else if (low_q) out_q <= 1'b0;
            end
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign mem_wr_req = (state_q == S_WREQ) && !mem_busy;
    assign mem_rd_req = (state_q == S_RREQ) && !mem_busy;
    assign mem_addr   = addr_q + AW'(idx_q);
    assign mem_wr_d   = wdata_q;
    assign mem_rd_num = len_q[5:0];
    assign rx_overrun = ovr_q;
endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench: transmitter and HyperRAM behavioural models, expected-byte and
// expected-request scoreboards checked every cycle, plus literal spot checks.
module tb_uart_mem_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        mem_rd_req, mem_wr_req;
    logic [31:0] mem_addr, mem_wr_d, mem_rd_d;
    logic [5:0]  mem_rd_num;
    logic        mem_rd_rdy, mem_busy;
    logic        rx_overrun;

    int vectors = 0;
    int miss = 0;

    logic [7:0]  txq [$];
    logic [63:0] wq [$];
    logic [63:0] rq [$];
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    uart_mem_bridge #(.TIMEOUT_CYCLES(40)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_d(mem_wr_d), .mem_rd_num(mem_rd_num), .mem_rd_d(mem_rd_d),
        .mem_rd_rdy(mem_rd_rdy), .mem_busy(mem_busy), .rx_overrun(rx_overrun)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic bad(input string nm);
        vectors++;
        miss++;
        $display("FAIL %s: got an event, expected none", nm);
    endtask

    // Transmitter: ready drops two cycles after a start and stays low two cycles.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                tx_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 tx_ready = 1'b1;
            end
        end
    end

    // Memory controller: busy for three cycles after a write, streams reads back-to-back.
    initial begin
        logic [7:0] ra;
        int n;
        mem_busy = 1'b0; mem_rd_rdy = 1'b0; mem_rd_d = '0;
        forever begin
            @(negedge clk);
            if (!reset && mem_wr_req) begin
                mem[mem_addr[7:0]] = mem_wr_d;
                @(posedge clk); #1 mem_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 mem_busy = 1'b0;
            end else if (!reset && mem_rd_req) begin
                ra = mem_addr[7:0];
                n  = int'(mem_rd_num);
                @(posedge clk); #1 mem_busy = 1'b1;
                @(posedge clk); #1;
                for (int k = 0; k < n; k++) begin
                    mem_rd_rdy = 1'b1;
                    mem_rd_d   = mem[ra + 8'(k)];
                    @(posedge clk); #1;
                end
                mem_rd_rdy = 1'b0; mem_busy = 1'b0;
            end
        end
    end

    // Per-cycle compare against the scoreboards and the transmit/memory rules.
    logic       busy_m = 1'b0, low_m = 1'b0, wr_prev = 1'b0, rd_prev = 1'b0;
    logic [7:0] held = '0;
    logic [63:0] ew, er;
    always @(negedge clk) begin
        if (reset) begin
            busy_m = 1'b0; low_m = 1'b0; wr_prev = 1'b0; rd_prev = 1'b0;
        end else begin
            if (mem_wr_req) begin
                if (wr_prev || mem_rd_req) bad("wr_pulse");
                chk("wr_busy", mem_busy, 0);
                if (wq.size() == 0) bad("wr_unexpected");
                else begin
                    ew = wq.pop_front();
                    chk("wr_addr", mem_addr, ew[63:32]);
                    chk("wr_data", mem_wr_d, ew[31:0]);
                end
            end
            if (mem_rd_req) begin
                if (rd_prev) bad("rd_pulse");
                chk("rd_busy", mem_busy, 0);
                if (rq.size() == 0) bad("rd_unexpected");
                else begin
                    er = rq.pop_front();
                    chk("rd_addr", mem_addr, er[63:32]);
                    chk("rd_num", mem_rd_num, er[31:0]);
                end
            end
            wr_prev = mem_wr_req;
            rd_prev = mem_rd_req;
            if (tx_start) begin
                if (busy_m) bad("tx_overlap");
                if (txq.size() == 0) bad("tx_extra");
                else chk("tx_byte", tx_data, txq.pop_front());
                busy_m = 1'b1; low_m = 1'b0; held = tx_data;
            end else if (busy_m) begin
                if (!tx_ready && !low_m) begin
                    low_m = 1'b1;
                    chk("tx_hold", tx_data, held);
                end else if (tx_ready && low_m) begin
                    busy_m = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic sb(input logic [7:0] b);
        repeat (2) @(posedge clk);
        send(b);
    endtask

    task automatic sw(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) sb(w[8*i +: 8]);
    endtask

    task automatic exw(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) txq.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_tx(input int budget);
        for (int i = 0; i < budget && txq.size() != 0; i++) @(negedge clk);
        chk("tx_drain", txq.size(), 0);
        repeat (12) @(posedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rd_req", mem_rd_req, 0);
        chk("rst_wr_req", mem_wr_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wr_d", mem_wr_d, 0);
        chk("rst_rd_num", mem_rd_num, 1);
        chk("rst_overrun", rx_overrun, 0);
    endtask

    task automatic ping();
        txq.push_back(8'hA5); exw(32'h0000_0103);
        sb(8'h03);
        wait_tx(200);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = {24'hDEADBE, 8'(i)};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        ping();

        // Two-word write to 0x10/0x11
        wq.push_back({32'h10, 32'h1122_3344});
        wq.push_back({32'h11, 32'h5566_7788});
        txq.push_back(8'hA5);
        sb(8'h01); sb(8'h02); sw(32'h0000_0010);
        sw(32'h1122_3344);
        @(negedge clk);
        chk("wr_latency", mem_wr_req, 1);
        repeat (10) @(posedge clk);
        sw(32'h5566_7788);
        wait_tx(200);
        chk("wq_empty", wq.size(), 0);
        chk("ovr_clear", rx_overrun, 0);

        // Three-word read back, with bytes injected mid-response
        rq.push_back({32'h10, 32'd3});
        txq.push_back(8'hA5);
        exw(32'h1122_3344); exw(32'h5566_7788); exw(32'hDEAD_BE12);
        sb(8'h02); sb(8'h03); sw(32'h0000_0010);
        repeat (15) @(posedge clk);
        send(8'h03);
        repeat (3) @(posedge clk);
        send(8'h03);
        wait_tx(400);
        chk("rq_empty", rq.size(), 0);
        chk("ovr_set", rx_overrun, 1);

        // Bad LEN, trailing bytes discarded, then PING after the quiet gap
        txq.push_back(8'hE3);
        sb(8'h02); sb(8'h20); sb(8'h00); sb(8'h00);
        wait_tx(200);
        repeat (60) @(posedge clk);
        ping();

        // Unknown command
        txq.push_back(8'hE1);
        sb(8'h55);
        wait_tx(200);
        repeat (60) @(posedge clk);

        // Silence after CMD
        txq.push_back(8'hE2);
        sb(8'h01);
        repeat (80) @(posedge clk);
        wait_tx(200);

        // Silence inside a data word: no write may be issued
        txq.push_back(8'hE2);
        sb(8'h01); sb(8'h01); sw(32'h0000_0020); sb(8'hAA); sb(8'hBB);
        repeat (80) @(posedge clk);
        wait_tx(200);
        chk("partial_no_wr", wq.size(), 0);
        ping();

        // Reset in the middle of a read response
        rq.push_back({32'h0, 32'd4});
        txq.push_back(8'hA5);
        for (int i = 0; i < 4; i++) exw({24'hDEADBE, 8'(i)});
        sb(8'h02); sb(8'h04); sw(32'h0000_0000);
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        txq.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        ping();
        chk("rq_final", rq.size(), 0);
        chk("wq_final", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule
